hazard_forward_ctrl: RTL and testbench

Parametrised hazard-detection and operand-forwarding controller for the ID stage of the pipelined core. It picks a forwarding source for each ID operand from a configurable number of downstream stages. It detects load-use hazards and stalls for a configurable number of bubbles, using a small registered stall FSM. It also handles a branch-flush request. It drives the PC and IF/ID enables, the ID/EX NOP insertion, and the two operand-mux selectors.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/fwd_select.sv | 44 ++++
 rtl/hazard_forward_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
// Holds the stall FSM state enum, operand source-mode encodings, the
// register-file selector value and helpers that decode which operands are live.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    // source_registers_signal encodings; 2'b11 is treated as "no operands".
    localparam logic [1:0] SRC_NONE    = 2'b00;
    localparam logic [1:0] SRC_RS1     = 2'b01;
    localparam logic [1:0] SRC_RS1_RS2 = 2'b10;

    // Operand-mux selector value meaning "read the register file".
    localparam int SEL_RF = 0;

    function automatic logic rs1_used(input logic [1:0] mode);
        return (mode == SRC_RS1) || (mode == SRC_RS1_RS2);
    endfunction

    function automatic logic rs2_used(input logic [1:0] mode);
        return (mode == SRC_RS1_RS2);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Forwarding-source priority encoder for one ID operand.
// Ports: i_used/i_rs operand, i_dest/i_rf_en packed stage destinations and
// write enables; o_sel = lowest matching stage + 1 (0 = register file),
// o_ex_hit = operand matches the EX stage (slice 0). Purely combinational.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic                               i_used,
    input  logic [REG_ADDR_W-1:0]              i_rs,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0]   i_dest,
    input  logic [FWD_STAGES-1:0]              i_rf_en,
    output logic [$clog2(FWD_STAGES+1)-1:0]    o_sel,
    output logic                               o_ex_hit
);

    localparam int SEL_W = $clog2(FWD_STAGES+1);

    logic [FWD_STAGES-1:0] w_hit;

    // x0 is hard-wired zero, so it never matches a producer.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            w_hit[k] = i_used && (i_rs != '0) && i_rf_en[k] &&
                       (i_dest[k*REG_ADDR_W +: REG_ADDR_W] == i_rs);
        end
    end

    // Scan oldest to youngest so the youngest (lowest index) hit wins.
    always_comb begin
        o_sel = SEL_W'(SEL_RF);
        for (int k = FWD_STAGES-1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_sel = SEL_W'(k + 1);
            end
        end
    end

    assign o_ex_hit = w_hit[0];

endmodule

// File: rtl/hazard_forward_ctrl.sv
// ID-stage hazard detection and operand forwarding: per-operand forward select,
// load-use stall FSM (LOAD_STALL_CYCLES bubbles), branch flush and optional
// event counters. Outputs are combinational from inputs and registered state.
// Ports: clk/rst_n; id_rs1/id_rs2/source_registers_signal describe the ID
// instruction; stage_destination/stage_rf_enable/ex_load_instruction describe
// downstream stages; flush discards the ID instruction. Outputs: pa/pb_selector,
// load_enable, pc_enable, nop_signal, stall_count, flush_count.
// Optional feature: define HAZARD_STATS_EN to build the saturating counters;
// otherwise both counter outputs are tied to zero.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES        = 3,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int REG_ADDR_W        = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [REG_ADDR_W-1:0]              id_rs1,
    input  logic [REG_ADDR_W-1:0]              id_rs2,
    input  logic [1:0]                         source_registers_signal,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0]   stage_destination,
    input  logic [FWD_STAGES-1:0]              stage_rf_enable,
    input  logic                               ex_load_instruction,
    input  logic                               flush,
    output logic [$clog2(FWD_STAGES+1)-1:0]    pa_selector,
    output logic [$clog2(FWD_STAGES+1)-1:0]    pb_selector,
    output logic                               load_enable,
    output logic                               pc_enable,
    output logic                               nop_signal,
    output logic [31:0]                        stall_count,
    output logic [31:0]                        flush_count
);

    localparam int SEL_W = $clog2(FWD_STAGES+1);
    localparam int CNT_W = $clog2(LOAD_STALL_CYCLES+1);

    logic             w_rs1_used;
    logic             w_rs2_used;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_ex_hit_a;
    logic             w_ex_hit_b;
    logic             w_hz;
    logic             w_stall;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_rs1_used = rs1_used(source_registers_signal);
    assign w_rs2_used = rs2_used(source_registers_signal);

    fwd_select #(
        .FWD_STAGES (FWD_STAGES),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .i_used   (w_rs1_used),
        .i_rs     (id_rs1),
        .i_dest   (stage_destination),
        .i_rf_en  (stage_rf_enable),
        .o_sel    (w_sel_a),
        .o_ex_hit (w_ex_hit_a)
    );

    fwd_select #(
        .FWD_STAGES (FWD_STAGES),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .i_used   (w_rs2_used),
        .i_rs     (id_rs2),
        .i_dest   (stage_destination),
        .i_rf_en  (stage_rf_enable),
        .o_sel    (w_sel_b),
        .o_ex_hit (w_ex_hit_b)
    );

    // Load in EX whose result a live ID operand needs: value not ready yet.
    // o_ex_hit already includes the EX write enable and the x0 filter.
    assign w_hz = ex_load_instruction && (w_ex_hit_a || w_ex_hit_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // r_cnt holds bubbles still owed after the current STALL cycle + 1;
    // leaving STALL when it reaches 1 yields exactly LOAD_STALL_CYCLES bubbles
    // counting the RUN cycle that detected the hazard.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        if (flush) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hz) begin
                        w_stall = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_state_nxt = STALL;
                            w_cnt_nxt   = CNT_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Reset is applied to the outputs combinationally so the pipeline is held
    // (and NOPs injected) for the whole time rst_n is low.
    always_comb begin
        pa_selector = '0;
        pb_selector = '0;
        load_enable = 1'b0;
        pc_enable   = 1'b0;
        nop_signal  = 1'b1;
        if (rst_n) begin
            pa_selector = w_sel_a;
            pb_selector = w_sel_b;
            if (flush) begin
                // Discard the ID instruction but let fetch proceed to the target.
                load_enable = 1'b1;
                pc_enable   = 1'b1;
                nop_signal  = 1'b1;
            end else if (w_stall) begin
                load_enable = 1'b0;
                pc_enable   = 1'b0;
                nop_signal  = 1'b1;
            end else begin
                load_enable = 1'b1;
                pc_enable   = 1'b1;
                nop_signal  = 1'b0;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!pc_enable && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    localparam int FWD = 3;
    localparam int L   = 3;
    localparam int W   = 5;
    localparam int SW  = $clog2(FWD+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [W-1:0]      id_rs1, id_rs2;
    logic [1:0]        mode;
    logic [FWD*W-1:0]  dest;
    logic [FWD-1:0]    en;
    logic              ex_load, flush;
    logic [SW-1:0]     pa_selector, pb_selector;
    logic              load_enable, pc_enable, nop_signal;
    logic [31:0]       stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    // Reference state: bubbles still owed after this cycle, and event totals.
    int          stall_left = 0;
    int unsigned m_stalls   = 0;
    int unsigned m_flushes  = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(
        .FWD_STAGES        (FWD),
        .LOAD_STALL_CYCLES (L),
        .REG_ADDR_W        (W)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .id_rs1                  (id_rs1),
        .id_rs2                  (id_rs2),
        .source_registers_signal (mode),
        .stage_destination       (dest),
        .stage_rf_enable         (en),
        .ex_load_instruction     (ex_load),
        .flush                   (flush),
        .pa_selector             (pa_selector),
        .pb_selector             (pb_selector),
        .load_enable             (load_enable),
        .pc_enable               (pc_enable),
        .nop_signal              (nop_signal),
        .stall_count             (stall_count),
        .flush_count             (flush_count)
    );

    task automatic cv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_sel(input logic [W-1:0] rs, input bit used);
        if (!used || rs == 0) return 0;
        for (int k = 0; k < FWD; k++) begin
            if (en[k] && dest[k*W +: W] == rs) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit u1();
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    function automatic bit u2();
        return (mode == 2'b10);
    endfunction

    // A load-use hazard exists exactly when the youngest producer of a live
    // operand is an EX load.
    function automatic bit m_hz();
        return ex_load && (exp_sel(id_rs1, u1()) == 1 || exp_sel(id_rs2, u2()) == 1);
    endfunction

    function automatic bit m_stalling();
        return !flush && (stall_left > 0 || m_hz());
    endfunction

    task automatic check_model(input string tag);
        logic [31:0] e_pa, e_pb, e_sc, e_fc;
        logic e_le, e_pe, e_nop;
        if (!rst_n) begin
            e_pa = 0; e_pb = 0; e_le = 0; e_pe = 0; e_nop = 1;
        end else begin
            e_pa = exp_sel(id_rs1, u1());
            e_pb = exp_sel(id_rs2, u2());
            if (flush) begin
                e_le = 1; e_pe = 1; e_nop = 1;
            end else if (m_stalling()) begin
                e_le = 0; e_pe = 0; e_nop = 1;
            end else begin
                e_le = 1; e_pe = 1; e_nop = 0;
            end
        end
`ifdef HAZARD_STATS_EN
        e_sc = m_stalls;
        e_fc = m_flushes;
`else
        e_sc = 0;
        e_fc = 0;
`endif
        cv({tag, ".pa"},    32'(pa_selector), e_pa);
        cv({tag, ".pb"},    32'(pb_selector), e_pb);
        cv({tag, ".le"},    32'(load_enable), 32'(e_le));
        cv({tag, ".pe"},    32'(pc_enable),   32'(e_pe));
        cv({tag, ".nop"},   32'(nop_signal),  32'(e_nop));
        cv({tag, ".scnt"},  stall_count, e_sc);
        cv({tag, ".fcnt"},  flush_count, e_fc);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Clock edge: advance the reference model with the inputs of this cycle.
    task automatic adv();
        @(posedge clk);
        if (!rst_n) begin
            stall_left = 0;
            m_stalls   = 0;
            m_flushes  = 0;
        end else begin
            if (m_stalling() && m_stalls != 32'hFFFF_FFFF) m_stalls++;
            if (flush && m_flushes != 32'hFFFF_FFFF) m_flushes++;
            if (flush)               stall_left = 0;
            else if (stall_left > 0) stall_left--;
            else if (m_hz())         stall_left = L - 1;
        end
        #1;
    endtask

    task automatic tick(input string tag);
        settle();
        check_model(tag);
        adv();
    endtask

    task automatic set_stage(input int k, input logic [W-1:0] d, input logic e);
        dest[k*W +: W] = d;
        en[k]          = e;
    endtask

    task automatic idle();
        mode = 2'b00; id_rs1 = 0; id_rs2 = 0;
        dest = '0; en = '0; ex_load = 0; flush = 0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        // Forwarding hits present while in reset: selectors must still read 0.
        mode = 2'b10; id_rs1 = 5; id_rs2 = 6;
        set_stage(0, 5, 1); set_stage(1, 6, 1);
        #3;
        cv("rst.pa",  32'(pa_selector), 0);
        cv("rst.pe",  32'(pc_enable),   0);
        cv("rst.le",  32'(load_enable), 0);
        cv("rst.nop", 32'(nop_signal),  1);
        cv("rst.sc",  stall_count,      0);
        adv(); adv();
        #3 rst_n = 1;

        // Operand reuse across stages.
        idle();
        mode = 2'b10; id_rs1 = 5; id_rs2 = 6;
        set_stage(0, 5, 1); set_stage(1, 6, 1); set_stage(2, 6, 1);
        settle();
        cv("reuse.pa",  32'(pa_selector), 1);
        cv("reuse.pb",  32'(pb_selector), 2);
        cv("reuse.pe",  32'(pc_enable),   1);
        cv("reuse.nop", 32'(nop_signal),  0);
        check_model("reuse");
        adv();

        // x0 and mode filtering.
        idle();
        mode = 2'b01; id_rs1 = 0; id_rs2 = 7; ex_load = 1;
        set_stage(0, 0, 1);
        settle();
        cv("x0.pa", 32'(pa_selector), 0);
        cv("x0.pe", 32'(pc_enable),   1);
        check_model("x0");
        adv();
        set_stage(0, 7, 1);
        settle();
        cv("mode.pb", 32'(pb_selector), 0);
        cv("mode.pe", 32'(pc_enable),   1);
        check_model("mode");
        adv();
        id_rs1 = 7;
        settle();
        cv("rs1hz.pe", 32'(pc_enable), 0);
        check_model("rs1hz");
        adv();
        idle();
        tick("drain1"); tick("drain2");

        // Multi-bubble stall, EX cleared after the detection cycle.
        mode = 2'b10; id_rs1 = 1; id_rs2 = 9; ex_load = 1;
        set_stage(0, 9, 1);
        for (int c = 0; c < L; c++) begin
            settle();
            cv($sformatf("bub%0d.pe", c),  32'(pc_enable),  0);
            cv($sformatf("bub%0d.nop", c), 32'(nop_signal), 1);
            check_model("bubble");
            adv();
            ex_load = 0; en = '0;
        end
        settle();
        cv("resume.pe",  32'(pc_enable),  1);
        cv("resume.nop", 32'(nop_signal), 0);
        check_model("resume");
        adv();

        // Flush with a hazard present, then flush in the 2nd STALL cycle.
        ex_load = 1; set_stage(0, 9, 1); flush = 1;
        settle();
        cv("fhz.nop", 32'(nop_signal), 1);
        cv("fhz.pe",  32'(pc_enable),  1);
        check_model("fhz");
        adv();
        flush = 0;
        tick("st1");
        flush = 1;
        settle();
        cv("fst.pe", 32'(pc_enable), 1);
        check_model("fst");
        adv();
        idle();
        settle();
        cv("fst_run.pe",  32'(pc_enable),  1);
        cv("fst_run.nop", 32'(nop_signal), 0);
        check_model("fst_run");
        adv();

        // Reset asserted in the middle of a stall.
        mode = 2'b10; id_rs2 = 9; ex_load = 1; set_stage(0, 9, 1);
        tick("pre_rst");
        #2 rst_n = 0;
        #1;
        stall_left = 0; m_stalls = 0; m_flushes = 0;
        cv("mrst.pe",  32'(pc_enable),   0);
        cv("mrst.nop", 32'(nop_signal),  1);
        cv("mrst.pb",  32'(pb_selector), 0);
        cv("mrst.sc",  stall_count,      0);
        cv("mrst.fc",  flush_count,      0);
        adv();
        #2 rst_n = 1;
        idle();
        settle();
        cv("post_rst.pe", 32'(pc_enable), 1);
        cv("post_rst.sc", stall_count,    0);
        check_model("post_rst");
        adv();

        // Statistics: 4 stall cycles and 2 flushes.
        mode = 2'b10; id_rs2 = 9; ex_load = 1; set_stage(0, 9, 1);
        tick("s1");
        ex_load = 0;
        tick("s2"); tick("s3");
        flush = 1;
        tick("s4");
        flush = 0; ex_load = 1;
        tick("s5");
        flush = 1;
        tick("s6");
        idle();
        tick("s7");
        settle();
`ifdef HAZARD_STATS_EN
        cv("stats.sc", stall_count, 4);
        cv("stats.fc", flush_count, 2);
`else
        cv("stats.sc", stall_count, 0);
        cv("stats.fc", flush_count, 0);
`endif
        check_model("stats");
        adv();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            mode    = 2'($urandom_range(0, 3));
            id_rs1  = W'($urandom_range(0, 7));
            id_rs2  = W'($urandom_range(0, 7));
            for (int k = 0; k < FWD; k++) begin
                set_stage(k, W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            ex_load = ($urandom_range(0, 2) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
